// File: rtl/splitter_tx_arbiter_pkg.sv
// Shared types for the REG_SPLITTER transmit arbiter: FSM state encoding,
// grant selector and a counter-width helper.
package splitter_tx_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOAD     = 2'd1,
        WAIT_ACK = 2'd2,
        GAP      = 2'd3
    } arb_state_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_ADC  = 2'd1,
        GNT_STAT = 2'd2
    } grant_t;

    // Bits needed to hold 0..maxVal; never narrower than one bit.
    function automatic int cntWidth(input int maxVal);
        return (maxVal < 2) ? 1 : $clog2(maxVal + 1);
    endfunction

endpackage

// File: rtl/splitter_tx_arbiter_tx_grant_rr.sv
// Two-requester grant logic with ADC burst limiting so a pending status word
// cannot be starved by a continuous ADC stream.
module tx_grant_rr
    import splitter_tx_arbiter_pkg::*;
#(
    parameter int BURST_LEN = 4
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   arbEn,
    input  logic   adcValid,
    input  logic   statValid,
    output grant_t grant
);

    localparam int            BW        = cntWidth(BURST_LEN);
    localparam logic [BW-1:0] BURST_MAX = BW'(BURST_LEN);

    logic [BW-1:0] burstCnt;
    grant_t        lastGrant;
    logic          statWins;

    assign statWins = (burstCnt == BURST_MAX) ||
                      ((lastGrant == GNT_ADC) && (burstCnt >= BURST_MAX));

    always_comb begin
        grant = GNT_NONE;
        if (arbEn) begin
            if (adcValid && statValid) begin
                grant = statWins ? GNT_STAT : GNT_ADC;
            end else if (statValid) begin
                grant = GNT_STAT;
            end else if (adcValid) begin
                grant = GNT_ADC;
            end
        end
    end

    // An ADC grant always counts; the burst count clears on a status grant or
    // whenever the arbiter sits idle with no status word waiting.
    always_ff @(posedge clk) begin
        if (rst) begin
            burstCnt  <= '0;
            lastGrant <= GNT_NONE;
        end else if (arbEn) begin
            case (grant)
                GNT_ADC: begin
                    lastGrant <= GNT_ADC;
                    if (burstCnt != BURST_MAX) begin
                        burstCnt <= burstCnt + BW'(1);
                    end
                end
                GNT_STAT: begin
                    lastGrant <= GNT_STAT;
                    burstCnt  <= '0;
                end
                default: begin
                    if (!statValid) begin
                        burstCnt <= '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/splitter_tx_arbiter.sv
// Shares the REG_SPLITTER byte serializer between the ADC stream and the host
// status word: one word per grant, write strobe, ack wait with timeout, gap.
module splitter_tx_arbiter
    import splitter_tx_arbiter_pkg::*;
#(
    parameter int BURST_LEN      = 4,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             adcValid,
    input  logic [31:0]      adcWord,
    output logic             adcReady,
    input  logic             statValid,
    input  logic [31:0]      statWord,
    output logic             statReady,
    output logic             write,
    output logic [31:0]      adcReg,
    input  logic             dataReceived,
    output logic             busy,
    output logic             errTimeout,
    output logic [CNT_W-1:0] wordCount
);

    localparam int               TO_W      = cntWidth(TIMEOUT_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
    localparam int               GAP_W     = cntWidth(GAP_CYCLES);
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam arb_state_t       POST_WAIT = (GAP_CYCLES == 0) ? IDLE : GAP;

    arb_state_t       state;
    arb_state_t       stateNext;
    grant_t           grant;
    logic             arbEn;
    logic [TO_W-1:0]  toCnt;
    logic [GAP_W-1:0] gapCnt;

    // Arbitration is held off during reset so no handshake can slip through.
    assign arbEn = (state == IDLE) && !rst;

    tx_grant_rr #(
        .BURST_LEN (BURST_LEN)
    ) u_grant (
        .clk       (clk),
        .rst       (rst),
        .arbEn     (arbEn),
        .adcValid  (adcValid),
        .statValid (statValid),
        .grant     (grant)
    );

    assign adcReady  = (grant == GNT_ADC);
    assign statReady = (grant == GNT_STAT);
    assign write     = (state == LOAD);
    assign busy      = (state != IDLE);

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (grant != GNT_NONE) begin
                    stateNext = LOAD;
                end
            end
            LOAD: begin
                stateNext = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (dataReceived || (toCnt == TO_LAST)) begin
                    stateNext = POST_WAIT;
                end
            end
            GAP: begin
                if (gapCnt == GAP_LAST) begin
                    stateNext = IDLE;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // An ack arriving on the final timeout cycle still counts as delivered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            adcReg     <= '0;
            wordCount  <= '0;
            toCnt      <= '0;
            gapCnt     <= '0;
            errTimeout <= 1'b0;
        end else begin
            state <= stateNext;
            case (state)
                IDLE: begin
                    if (grant == GNT_ADC) begin
                        adcReg <= adcWord;
                    end else if (grant == GNT_STAT) begin
                        adcReg <= statWord;
                    end
                end
                LOAD: begin
                    toCnt <= '0;
                end
                WAIT_ACK: begin
                    gapCnt <= '0;
                    if (dataReceived) begin
                        wordCount <= wordCount + CNT_W'(1);
                    end else if (toCnt == TO_LAST) begin
                        errTimeout <= 1'b1;
                    end else begin
                        toCnt <= toCnt + TO_W'(1);
                    end
                end
                GAP: begin
                    gapCnt <= gapCnt + GAP_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_splitter_tx_arbiter.sv
// Bench for splitter_tx_arbiter: directed scenarios then random traffic, all
// checked every cycle against a timestamp-based transaction model.
module tb_splitter_tx_arbiter;

    localparam int BURST_LEN      = 4;
    localparam int GAP_CYCLES     = 2;
    localparam int TIMEOUT_CYCLES = 16;
    localparam int CNT_W          = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             adcValid = 1'b0;
    logic [31:0]      adcWord = '0;
    logic             adcReady;
    logic             statValid = 1'b0;
    logic [31:0]      statWord = '0;
    logic             statReady;
    logic             write;
    logic [31:0]      adcReg;
    logic             dataReceived = 1'b0;
    logic             busy;
    logic             errTimeout;
    logic [CNT_W-1:0] wordCount;

    int assertCount = 0;
    int failCount   = 0;
    int cyc         = 0;
    bit checkEn     = 1'b0;
    int ackDelay    = -1;

    // Model: a word is granted at mGrantCyc, written the cycle after, and may be
    // acked from two cycles after the grant until the timeout window closes.
    bit          mInFlight = 1'b0;
    int          mGrantCyc = 0;
    int          mFreeAt   = 0;
    logic [31:0] mReg      = '0;
    int          mCount    = 0;
    bit          mErr      = 1'b0;
    int          mBurst    = 0;

    int          lastG = 0;
    logic        obsAdcReady;
    logic        obsStatReady;
    int          grantLog[$];
    int          expOrder[10] = '{1, 1, 1, 1, 2, 1, 1, 1, 1, 2};
    int          writeCyc;
    int          errCyc;
    int          countBefore;
    bit          seen15;
    logic        rAv, rSv, rR, rDr;
    logic [31:0] rAw, rSw;

    splitter_tx_arbiter #(
        .BURST_LEN      (BURST_LEN),
        .GAP_CYCLES     (GAP_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .adcValid     (adcValid),
        .adcWord      (adcWord),
        .adcReady     (adcReady),
        .statValid    (statValid),
        .statWord     (statWord),
        .statReady    (statReady),
        .write        (write),
        .adcReg       (adcReg),
        .dataReceived (dataReceived),
        .busy         (busy),
        .errTimeout   (errTimeout),
        .wordCount    (wordCount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic checkOutput(input int g, input bit idle);
        chk("adcReady",   32'(adcReady),   32'(g == 1));
        chk("statReady",  32'(statReady),  32'(g == 2));
        chk("write",      32'(write),      32'(mInFlight && (cyc == mGrantCyc + 1)));
        chk("busy",       32'(busy),       32'(!idle));
        chk("adcReg",     adcReg,          mReg);
        chk("wordCount",  32'(wordCount),  32'(mCount));
        chk("errTimeout", 32'(errTimeout), 32'(mErr));
    endtask

    // Drives one cycle of inputs, checks the DUT against the model, then advances the model.
    task automatic applyStimulus(input logic r, input logic av, input logic [31:0] aw,
                                 input logic sv, input logic [31:0] sw, input logic dr);
        bit   idle;
        int   g;
        logic drEff;
        drEff = dr;
        if (ackDelay >= 0 && mInFlight && (cyc == mGrantCyc + 2 + ackDelay)) drEff = 1'b1;
        rst          = r;
        adcValid     = av;
        adcWord      = aw;
        statValid    = sv;
        statWord     = sw;
        dataReceived = drEff;
        #1;
        idle = !mInFlight && (cyc >= mFreeAt);
        g = 0;
        if (idle && !r) begin
            if (av && sv)  g = (mBurst >= BURST_LEN) ? 2 : 1;
            else if (sv)   g = 2;
            else if (av)   g = 1;
        end
        lastG        = g;
        obsAdcReady  = adcReady;
        obsStatReady = statReady;
        if (checkEn) checkOutput(g, idle);
        if (r) begin
            mInFlight = 1'b0;
            mFreeAt   = cyc + 1;
            mReg      = '0;
            mCount    = 0;
            mErr      = 1'b0;
            mBurst    = 0;
        end else if (idle) begin
            if (g == 1)              mBurst = (mBurst < BURST_LEN) ? mBurst + 1 : BURST_LEN;
            else if (g == 2 || !sv)  mBurst = 0;
            if (g != 0) begin
                mInFlight = 1'b1;
                mGrantCyc = cyc;
                mReg      = (g == 1) ? aw : sw;
            end
        end else if (mInFlight && (cyc >= mGrantCyc + 2)) begin
            if (drEff) begin
                mCount    = (mCount + 1) % (1 << CNT_W);
                mInFlight = 1'b0;
                mFreeAt   = cyc + 1 + GAP_CYCLES;
            end else if (cyc == mGrantCyc + 1 + TIMEOUT_CYCLES) begin
                mErr      = 1'b1;
                mInFlight = 1'b0;
                mFreeAt   = cyc + 1 + GAP_CYCLES;
            end
        end
        checkEn = 1'b1;
        @(negedge clk);
        cyc++;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    endtask

    initial begin
        @(negedge clk);

        // Reset
        applyStimulus(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
        applyStimulus(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
        idleCycles(2);

        // Scenario 1: single ADC word, ack ten cycles after the write strobe
        $display("[TB] ADC-only word");
        applyStimulus(1'b0, 1'b1, 32'hA1B2C3D4, 1'b0, '0, 1'b0);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 32'hA1B2C3D4, 1'b0, '0, 1'b0);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
        chk("t1_wordCount", 32'(wordCount), 32'd1);
        chk("t1_adcReg", adcReg, 32'hA1B2C3D4);
        idleCycles(5);
        chk("t1_busy_after_gap", 32'(busy), 32'd0);

        // Scenario 2: both requesters continuously valid
        $display("[TB] burst fairness");
        ackDelay = 2;
        for (int i = 0; i < 400 && grantLog.size() < 10; i++) begin
            applyStimulus(1'b0, 1'b1, 32'hADC0FFEE, 1'b1, 32'h57A70102, 1'b0);
            if (obsAdcReady === 1'b1)  grantLog.push_back(1);
            if (obsStatReady === 1'b1) grantLog.push_back(2);
        end
        chk("t2_grant_count", 32'(grantLog.size()), 32'd10);
        for (int i = 0; i < grantLog.size() && i < 10; i++) chk("t2_grant_order", 32'(grantLog[i]), 32'(expOrder[i]));
        idleCycles(20);
        ackDelay = -1;

        // Scenario 3: no ack, timeout abort, then a normal grant
        $display("[TB] ack timeout");
        countBefore = mCount;
        writeCyc = -1;
        errCyc   = -1;
        applyStimulus(1'b0, 1'b1, 32'hDEADBEEF, 1'b0, '0, 1'b0);
        for (int i = 0; i < 80 && errCyc < 0; i++) begin
            if (write === 1'b1 && writeCyc < 0) writeCyc = cyc;
            if (errTimeout === 1'b1) errCyc = cyc;
            applyStimulus(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
        end
        chk("t3_err_delay", 32'(errCyc - writeCyc), 32'(TIMEOUT_CYCLES + 1));
        chk("t3_count_hold", 32'(wordCount), 32'(countBefore));
        idleCycles(5);
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 32'h51510003, 1'b0);
        chk("t3_next_grant", 32'(obsStatReady), 32'd1);
        ackDelay = 0;
        idleCycles(8);
        ackDelay = -1;
        chk("t3_next_ack", 32'(wordCount), 32'((countBefore + 1) % (1 << CNT_W)));

        // Scenario 4: reset while waiting for the ack
        $display("[TB] reset mid-word");
        applyStimulus(1'b0, 1'b1, 32'h13572468, 1'b0, '0, 1'b0);
        idleCycles(3);
        applyStimulus(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
        chk("t4_busy", 32'(busy), 32'd0);
        chk("t4_write", 32'(write), 32'd0);
        chk("t4_adcReg", adcReg, 32'd0);
        chk("t4_wordCount", 32'(wordCount), 32'd0);
        chk("t4_errTimeout", 32'(errTimeout), 32'd0);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
        chk("t4_late_ack", 32'(wordCount), 32'd0);

        // Scenario 5: stray acks in IDLE and in GAP
        $display("[TB] stray acks");
        idleCycles(2);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
        chk("t5_idle_ack", 32'(wordCount), 32'd0);
        chk("t5_idle_busy", 32'(busy), 32'd0);
        ackDelay = 1;
        applyStimulus(1'b0, 1'b1, 32'h0BADF00D, 1'b0, '0, 1'b0);
        idleCycles(3);
        ackDelay = -1;
        applyStimulus(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
        idleCycles(2);
        chk("t5_gap_ack", 32'(wordCount), 32'd1);

        // Scenario 6: word counter wraps at its maximum
        $display("[TB] wordCount wrap");
        ackDelay = 0;
        seen15 = 1'b0;
        for (int i = 0; i < 400 && !(seen15 && mCount == 0); i++) begin
            applyStimulus(1'b0, 1'b1, 32'(i), 1'b0, '0, 1'b0);
            if (mCount == (1 << CNT_W) - 1) seen15 = 1'b1;
        end
        chk("t6_wrap", 32'(wordCount), 32'd0);
        idleCycles(6);
        ackDelay = -1;

        // Random traffic with occasional resets and stray acks
        $display("[TB] random traffic");
        rAv = 1'b0; rSv = 1'b0; rAw = '0; rSw = '0;
        for (int i = 0; i < 3000; i++) begin
            rDr = ($urandom_range(4) == 0);
            rR  = ($urandom_range(499) == 0);
            applyStimulus(rR, rAv, rAw, rSv, rSw, rDr);
            if (lastG == 1 || !rAv) begin
                rAv = ($urandom_range(2) == 0);
                rAw = $urandom();
            end else if ($urandom_range(19) == 0) begin
                rAv = 1'b0;
            end
            if (lastG == 2 || !rSv) begin
                rSv = ($urandom_range(4) == 0);
                rSw = $urandom();
            end else if ($urandom_range(19) == 0) begin
                rSv = 1'b0;
            end
        end
        idleCycles(40);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
